dit_bfproc: RTL and testbench



---
 rtl/fft_pkg.sv | 17 +
 rtl/dit_bfproc_if.sv | 32 +++
 rtl/ccmul_pipe.sv | 56 +++++
 rtl/dit_bfproc.sv | 111 +++++++++++
 tb/tb_dit_bfproc.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared FFT widths, Q-format shift and the W+2 -> W saturation helpers.
package fft_pkg;
  localparam int W   = 8;
  localparam int W1  = W + 1;
  localparam int W2  = W + W1;
  localparam int QSH = W - 1;

  // Fits in W signed bits iff the top three bits agree.
  function automatic logic ovf_w(input logic [W+1:0] x);
    return !((x[W+1:W-1] == '0) || (x[W+1:W-1] == '1));
  endfunction

  function automatic logic [W-1:0] sat_w(input logic [W+1:0] x);
    if (!ovf_w(x)) return x[W-1:0];
    return x[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  endfunction
endpackage

// File: rtl/dit_bfproc_if.sv
// Sample/twiddle input and D/E result handshake bundle; inv_in exists only with DIT_BFPROC_CONJ_EN.
interface dit_bfproc_if;
  import fft_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  Are_in, Aim_in, Bre_in, Bim_in, c_in;
  logic signed [W1-1:0] cps_in, cms_in;
`ifdef DIT_BFPROC_CONJ_EN
  logic                 inv_in;
`endif
  logic                 out_valid;
  logic                 out_ready;
  logic signed [W-1:0]  Dre_out, Dim_out, Ere_out, Eim_out;
  logic                 sat_out;

  modport master (
`ifdef DIT_BFPROC_CONJ_EN
    output inv_in,
`endif
    output in_valid, Are_in, Aim_in, Bre_in, Bim_in, c_in, cps_in, cms_in, out_ready,
    input  in_ready, out_valid, Dre_out, Dim_out, Ere_out, Eim_out, sat_out
  );

  modport slave (
`ifdef DIT_BFPROC_CONJ_EN
    input  inv_in,
`endif
    input  in_valid, Are_in, Aim_in, Bre_in, Bim_in, c_in, cps_in, cms_in, out_ready,
    output in_ready, out_valid, Dre_out, Dim_out, Ere_out, Eim_out, sat_out
  );
endinterface

// File: rtl/ccmul_pipe.sv
// Two-stage 3-multiplier complex multiply T = B*(c+js), floor-shifted back to W+1 bits.
// hold freezes both stages; with DIT_BFPROC_CONJ_EN, inv selects the conjugate twiddle.
module ccmul_pipe
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hold,
  input  logic                 in_vld,
  input  logic signed [W-1:0]  bre,
  input  logic signed [W-1:0]  bim,
  input  logic signed [W-1:0]  c,
  input  logic signed [W1-1:0] cps,
  input  logic signed [W1-1:0] cms,
`ifdef DIT_BFPROC_CONJ_EN
  input  logic                 inv,
`endif
  output logic                 out_vld,
  output logic signed [W1-1:0] tre,
  output logic signed [W1-1:0] tim
);
  logic signed [W1-1:0] bdiff, kr, ki;
  logic signed [W2-1:0] z, pr, pi;
  logic                 v2;

  assign bdiff = W1'(bre) - W1'(bim);

  // Conjugating the twiddle only flips s, i.e. swaps c+s and c-s.
`ifdef DIT_BFPROC_CONJ_EN
  assign kr = inv ? cps : cms;
  assign ki = inv ? cms : cps;
`else
  assign kr = cms;
  assign ki = cps;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2      <= 1'b0;
      z       <= '0;
      pr      <= '0;
      pi      <= '0;
      out_vld <= 1'b0;
      tre     <= '0;
      tim     <= '0;
    end else if (!hold) begin
      v2      <= in_vld;
      z       <= W2'(c) * W2'(bdiff);
      pr      <= W2'(kr) * W2'(bim);
      pi      <= W2'(ki) * W2'(bre);
      out_vld <= v2;
      tre     <= W1'(((W2+1)'(pr) + (W2+1)'(z)) >>> QSH);
      tim     <= W1'(((W2+1)'(pi) - (W2+1)'(z)) >>> QSH);
    end
  end
endmodule

// File: rtl/dit_bfproc.sv
// Radix-2 DIT butterfly: T = B*W, D = (A+T)/2, E = (A-T)/2, saturated; 4-edge latency, 1 sample/clk.
// A stalled output freezes every stage (in_ready = !stall). DIT_BFPROC_CONJ_EN adds inv_in for c - js.
module dit_bfproc
  import fft_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  dit_bfproc_if.slave bus
);
  logic                 stall, en;
  logic                 v1, v3, v4;
  logic signed [W-1:0]  are1, aim1, bre1, bim1, c1;
  logic signed [W1-1:0] cps1, cms1;
`ifdef DIT_BFPROC_CONJ_EN
  logic                 inv1;
`endif
  logic signed [W-1:0]  are2, aim2, are3, aim3;
  logic signed [W1-1:0] tre3, tim3;
  logic signed [W+1:0]  dre_h, dim_h, ere_h, eim_h;
  logic signed [W-1:0]  dre4, dim4, ere4, eim4;
  logic                 sat4;

  assign stall        = v4 && !bus.out_ready;
  assign en           = !stall;
  assign bus.in_ready = en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1   <= 1'b0;
      are1 <= '0;
      aim1 <= '0;
      bre1 <= '0;
      bim1 <= '0;
      c1   <= '0;
      cps1 <= '0;
      cms1 <= '0;
`ifdef DIT_BFPROC_CONJ_EN
      inv1 <= 1'b0;
`endif
      are2 <= '0;
      aim2 <= '0;
      are3 <= '0;
      aim3 <= '0;
    end else if (en) begin
      v1   <= bus.in_valid;
      are1 <= bus.Are_in;
      aim1 <= bus.Aim_in;
      bre1 <= bus.Bre_in;
      bim1 <= bus.Bim_in;
      c1   <= bus.c_in;
      cps1 <= bus.cps_in;
      cms1 <= bus.cms_in;
`ifdef DIT_BFPROC_CONJ_EN
      inv1 <= bus.inv_in;
`endif
      are2 <= are1;
      aim2 <= aim1;
      are3 <= are2;
      aim3 <= aim2;
    end
  end

  ccmul_pipe u_ccmul (
    .clk     (clk),
    .reset   (reset),
    .hold    (stall),
    .in_vld  (v1),
    .bre     (bre1),
    .bim     (bim1),
    .c       (c1),
    .cps     (cps1),
    .cms     (cms1),
`ifdef DIT_BFPROC_CONJ_EN
    .inv     (inv1),
`endif
    .out_vld (v3),
    .tre     (tre3),
    .tim     (tim3)
  );

  // W+2 bits hold any A +/- T without wrap before the halving shift.
  assign dre_h = ((W+2)'(are3) + (W+2)'(tre3)) >>> 1;
  assign dim_h = ((W+2)'(aim3) + (W+2)'(tim3)) >>> 1;
  assign ere_h = ((W+2)'(are3) - (W+2)'(tre3)) >>> 1;
  assign eim_h = ((W+2)'(aim3) - (W+2)'(tim3)) >>> 1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v4   <= 1'b0;
      dre4 <= '0;
      dim4 <= '0;
      ere4 <= '0;
      eim4 <= '0;
      sat4 <= 1'b0;
    end else if (en) begin
      v4   <= v3;
      dre4 <= sat_w(dre_h);
      dim4 <= sat_w(dim_h);
      ere4 <= sat_w(ere_h);
      eim4 <= sat_w(eim_h);
      sat4 <= ovf_w(dre_h) || ovf_w(dim_h) || ovf_w(ere_h) || ovf_w(eim_h);
    end
  end

  assign bus.out_valid = v4;
  assign bus.Dre_out   = dre4;
  assign bus.Dim_out   = dim4;
  assign bus.Ere_out   = ere4;
  assign bus.Eim_out   = eim4;
  assign bus.sat_out   = sat4;
endmodule

// File: tb/tb_dit_bfproc.sv
// Scoreboard bench for dit_bfproc: directed vectors, backpressure, streaming and mid-stream reset.
module tb_dit_bfproc;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int compared   = 0;
  int mismatched = 0;

  typedef struct { int are, aim, bre, bim, c, cps, cms; bit inv; } smp_t;
  typedef struct packed {
    logic signed [7:0] dre;
    logic signed [7:0] dim;
    logic signed [7:0] ere;
    logic signed [7:0] eim;
    logic              sat;
  } obs_t;

  obs_t sbq[$];

  dit_bfproc_if bus();
  dit_bfproc dut (.clk(clk), .reset(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  function automatic obs_t mk(int dre, int dim, int ere, int eim, bit sat);
    obs_t o;
    o.dre = 8'(dre);
    o.dim = 8'(dim);
    o.ere = 8'(ere);
    o.eim = 8'(eim);
    o.sat = sat;
    return o;
  endfunction

  // Reference: T = B*(c +/- js) via the c+s / c-s form, floor shifts, clip to 8 bits.
  function automatic obs_t model(smp_t s);
    int z, kr, ki, tre, tim;
    int v[4];
    bit sat;
    z   = s.c * (s.bre - s.bim);
    kr  = s.inv ? s.cps : s.cms;
    ki  = s.inv ? s.cms : s.cps;
    tre = (kr * s.bim + z) >>> 7;
    tim = (ki * s.bre - z) >>> 7;
    v[0] = (s.are + tre) >>> 1;
    v[1] = (s.aim + tim) >>> 1;
    v[2] = (s.are - tre) >>> 1;
    v[3] = (s.aim - tim) >>> 1;
    sat = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (v[k] > 127) begin v[k] = 127; sat = 1'b1; end
      else if (v[k] < -128) begin v[k] = -128; sat = 1'b1; end
    end
    return mk(v[0], v[1], v[2], v[3], sat);
  endfunction

  function automatic smp_t rnd_smp();
    smp_t s;
    int sn;
    s.are = int'($urandom_range(0, 255)) - 128;
    s.aim = int'($urandom_range(0, 255)) - 128;
    s.bre = int'($urandom_range(0, 255)) - 128;
    s.bim = int'($urandom_range(0, 255)) - 128;
    s.c   = int'($urandom_range(0, 254)) - 127;
    sn    = int'($urandom_range(0, 254)) - 127;
    s.cps = s.c + sn;
    s.cms = s.c - sn;
`ifdef DIT_BFPROC_CONJ_EN
    s.inv = 1'($urandom_range(0, 1));
`else
    s.inv = 1'b0;
`endif
    return s;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.dre = bus.Dre_out;
    o.dim = bus.Dim_out;
    o.ere = bus.Ere_out;
    o.eim = bus.Eim_out;
    o.sat = bus.sat_out;
    return o;
  endfunction

  task automatic drive(input smp_t s);
    bus.Are_in = 8'(s.are);
    bus.Aim_in = 8'(s.aim);
    bus.Bre_in = 8'(s.bre);
    bus.Bim_in = 8'(s.bim);
    bus.c_in   = 8'(s.c);
    bus.cps_in = 9'(s.cps);
    bus.cms_in = 9'(s.cms);
`ifdef DIT_BFPROC_CONJ_EN
    bus.inv_in = s.inv;
`endif
  endtask

  task automatic test_reset;
    obs_t o;
    #12;
    o = observe();
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid);
    end
    compared++;
    if (o !== '0) begin
      mismatched++; $display("FAIL reset_outputs got=%h want=0", o);
    end
    compared++;
    if (bus.in_ready !== 1'b1) begin
      mismatched++; $display("FAIL reset_in_ready got=%0b want=1", bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed(input string nm, input smp_t s,
                               input int dre, input int dim, input int ere, input int eim, input bit sat);
    int lat;
    obs_t o, x;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drive(s);
    bus.in_valid = 1'b1;
    #1;
    compared++;
    if (bus.in_ready !== 1'b1) begin
      mismatched++; $display("FAIL %s in_ready got=%0b want=1", nm, bus.in_ready);
    end
    sbq.push_back(mk(dre, dim, ere, eim, sat));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    compared++;
    if (lat != 4) begin
      mismatched++; $display("FAIL %s latency got=%0d want=4", nm, lat);
    end
    if (bus.out_valid === 1'b1 && sbq.size() > 0) begin
      x = sbq.pop_front();
      o = observe();
      compared++;
      if (o !== x) begin
        mismatched++;
        $display("FAIL %s result got D=(%0d,%0d) E=(%0d,%0d) sat=%0b want D=(%0d,%0d) E=(%0d,%0d) sat=%0b",
                 nm, o.dre, o.dim, o.ere, o.eim, o.sat, x.dre, x.dim, x.ere, x.eim, x.sat);
      end
    end else begin
      sbq.delete();
    end
    @(posedge clk); #1;
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++; $display("FAIL %s duplicate got out_valid=%0b want=0", nm, bus.out_valid);
    end
  endtask

  task automatic test_backpressure;
    smp_t cur;
    obs_t o, x, held_o;
    int sent = 0;
    int got = 0;
    bit held = 1'b0;
    held_o = '0;
    cur = rnd_smp();
    for (int cyc = 0; cyc < 400 && got < 8; cyc++) begin
      @(posedge clk); #1;
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_valid  = (sent < 8);
      drive(cur);
      @(negedge clk);
      o = observe();
      compared++;
      if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
        mismatched++;
        $display("FAIL bp_in_ready got=%0b want=%0b", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      end
      if (held) begin
        compared++;
        if (o !== held_o || bus.out_valid !== 1'b1) begin
          mismatched++; $display("FAIL bp_hold got=%h/%0b want=%h/1", o, bus.out_valid, held_o);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sbq.push_back(model(cur));
        sent++;
        cur = rnd_smp();
      end
      if (bus.out_valid && bus.out_ready) begin
        compared++;
        if (sbq.size() == 0) begin
          mismatched++; $display("FAIL bp_unexpected got=%h want=none", o);
        end else begin
          x = sbq.pop_front();
          if (o !== x) begin
            mismatched++;
            $display("FAIL bp_result #%0d got D=(%0d,%0d) E=(%0d,%0d) sat=%0b want D=(%0d,%0d) E=(%0d,%0d) sat=%0b",
                     got, o.dre, o.dim, o.ere, o.eim, o.sat, x.dre, x.dim, x.ere, x.eim, x.sat);
          end
        end
        got++;
      end
      held   = bus.out_valid && !bus.out_ready;
      held_o = o;
    end
    bus.in_valid = 1'b0;
    compared++;
    if (got != 8 || sbq.size() != 0) begin
      mismatched++; $display("FAIL bp_count got=%0d left=%0d want=8 left=0", got, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_streaming;
    smp_t cur;
    obs_t o, x;
    int sent = 0;
    int got = 0;
    int first = -1;
    int last = -1;
    cur = rnd_smp();
    for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      bus.in_valid  = (sent < 16);
      drive(cur);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        sbq.push_back(model(cur));
        sent++;
        cur = rnd_smp();
      end
      if (bus.out_valid === 1'b1) begin
        if (first < 0) first = cyc;
        last = cyc;
        o = observe();
        compared++;
        if (sbq.size() == 0) begin
          mismatched++; $display("FAIL stream_unexpected got=%h want=none", o);
        end else begin
          x = sbq.pop_front();
          if (o !== x) begin
            mismatched++;
            $display("FAIL stream_result #%0d got D=(%0d,%0d) E=(%0d,%0d) sat=%0b want D=(%0d,%0d) E=(%0d,%0d) sat=%0b",
                     got, o.dre, o.dim, o.ere, o.eim, o.sat, x.dre, x.dim, x.ere, x.eim, x.sat);
          end
        end
        got++;
      end
    end
    bus.in_valid = 1'b0;
    compared++;
    if (first != 4) begin
      mismatched++; $display("FAIL stream_latency got=%0d want=4", first);
    end
    compared++;
    if (got != 16 || last - first != 15) begin
      mismatched++; $display("FAIL stream_rate got=%0d results over %0d cycles want=16 over 15", got, last - first);
      sbq.delete();
    end
  endtask

  task automatic test_reset_midstream;
    smp_t s_sat, s_basic;
    obs_t o;
    s_sat   = '{0, 127, 127, 127, 90, 180, 0, 1'b0};
    s_basic = '{40, 20, 60, -30, 127, 127, 127, 1'b0};
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = (k < 3);
      drive(k == 0 ? s_sat : s_basic);
    end
    @(posedge clk);
    @(negedge clk);
    compared++;
    if (bus.out_valid !== 1'b1 || bus.sat_out !== 1'b1) begin
      mismatched++;
      $display("FAIL midrst_pre got valid=%0b sat=%0b want valid=1 sat=1", bus.out_valid, bus.sat_out);
    end
    #1 rst_n = 1'b0;
    #1;
    o = observe();
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++; $display("FAIL midrst_out_valid got=%0b want=0", bus.out_valid);
    end
    compared++;
    if (o !== '0) begin
      mismatched++; $display("FAIL midrst_outputs got=%h want=0", o);
    end
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    smp_t zero;
    zero = '{0, 0, 0, 0, 0, 0, 0, 1'b0};
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(zero);

    test_reset;
    test_directed("fwd_basic", '{40, 20, 60, -30, 127, 127, 127, 1'b0}, 49, -5, -10, 25, 1'b0);
    test_directed("minus_j",   '{0, 0, 64, 0, 0, -127, 127, 1'b0},       0, -32, 0, 32, 1'b0);
`ifdef DIT_BFPROC_CONJ_EN
    test_directed("conj_j",    '{0, 0, 64, 0, 0, -127, 127, 1'b1},       0, 31, 0, -32, 1'b0);
`endif
    test_directed("saturate",  '{0, 127, 127, 127, 90, 180, 0, 1'b0},    0, 127, 0, -26, 1'b1);
    test_backpressure;
    test_streaming;
    test_reset_midstream;
    test_directed("post_reset", '{40, 20, 60, -30, 127, 127, 127, 1'b0}, 49, -5, -10, 25, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
